sram_access_engine: RTL
=======================

# sram_access_engine

Responder end of the cache-to-SRAM request interface. Accepts one 32-bit word read or write from the cache controller, remaps the byte address into the data-memory window, and executes it as two sequential 16-bit accesses on the external SRAM bus (low halfword first). A one-cycle `done` pulse marks completion, and read data is held stable until the next read completes.

## Interface
- `WAIT_CYCLES`, default 2: extra SRAM cycles per halfword access. Each phase lasts WAIT_CYCLES+1 cycles. Legal range 1..7.
- `BASE_OFFSET`, default 1024: byte offset subtracted from the request address.
- Reset is `rst`, synchronous, active-high. The clock is `clk`.
- `clk`  in  1  system clock
- `rst`  in  1  synchronous active-high reset
- `wr_en`  in  1  write request, level, held until `done`
- `rd_en`  in  1  read request, level, held until `done`
- `address`  in  32  byte address of the word
- `write_data`  in  32  word to write
- `read_data`  out  32  last word read (registered)
- `done`  out  1  one-cycle completion pulse
- `SRAM_DQ`  inout  16  SRAM data bus; driven only during write phases, otherwise Z
- `SRAM_ADDR`  out  18  SRAM halfword address
- `SRAM_WE_N`  out  1  SRAM write enable, active-low

## Operation
- States: IDLE, LO, HI, FIN.
- IDLE: if `wr_en` or `rd_en` is sampled high, latch the following, then go to LO:
  - op (write wins if both are high)
  - `address`
  - `write_data`
- Address arithmetic:
  - offset = `address[17:0]` − BASE_OFFSET, 18-bit modulo (wraps, no error).
  - `SRAM_ADDR` = {1'b0, offset[17:2], h}, where h = 0 in LO and 1 in HI.
  - offset[1:0] is ignored.
- LO and HI each last WAIT_CYCLES+1 cycles, timed by a wait counter that is reloaded on every phase entry.
- Write phase:
  - `SRAM_DQ` = `write_data[15:0]` in LO and `[31:16]` in HI, driven for the whole phase.
  - `SRAM_WE_N` = 0 for every cycle of the phase except the last, which is 1 for address/data hold.
- Read phase:
  - `SRAM_DQ` is Z and `SRAM_WE_N` = 1.
  - `SRAM_DQ` is captured on the last cycle of the phase: LO fills `read_data[15:0]` staging, HI fills `[31:16]`.
  - `read_data` updates as a full word on entry to FIN, never half-updated.
- FIN: `done` = 1 for exactly one cycle, then go to IDLE.
- The requester must deassert its enable in the cycle after `done`. An enable still high in IDLE starts a new transaction.
- Inputs changing during LO/HI/FIN are ignored because all operands are latched.
- `SRAM_ADDR` holds its last value in IDLE and FIN.

## Timing
- Reset values:
  - state IDLE
  - `done` 0
  - `read_data` 0
  - `SRAM_WE_N` 1
  - `SRAM_ADDR` 0
  - `SRAM_DQ` Z
  - wait counter 0
- Latency: with the request sampled at edge 0, `done` is high in cycle 2·(WAIT_CYCLES+1)+1. For WAIT_CYCLES=2 that is cycle 7, with LO in cycles 1–3, HI in 4–6 and FIN in 7.
- Back-to-back throughput: one word per 2·(WAIT_CYCLES+1)+2 cycles (FIN, then one IDLE sample cycle).
- Reset during any state:
  - next edge returns to IDLE with `SRAM_WE_N` = 1 and DQ Z.
  - no `done` pulse is issued.
  - a partially written word is left as-is in SRAM.
- `done` is never asserted in two consecutive cycles.

## Structure
- Shared package `sram_pkg`:
  - state enum (IDLE/LO/HI/FIN)
  - `SRAM_AW` = 18
  - `SRAM_DW` = 16
  - default `BASE_OFFSET`
  - default `WAIT_CYCLES`
- Single flat module. The wait counter and tristate driver stay inline; no sub-module is warranted.
- The bench uses a behavioural 256K×16 SRAM model (combinational read, write on WE_N low), which is not part of the RTL.

## Test plan
- **Write to base** (WAIT_CYCLES=2): `wr_en`, `address`=0x400, `write_data`=0x12345678.
  - SRAM[0] = 0x5678 and SRAM[1] = 0x1234.
  - `SRAM_WE_N` low in cycles 1–2 and 4–5.
  - `done` high only in cycle 7.
- **Read back**: `rd_en`, `address`=0x400.
  - `read_data` = 0x12345678 in cycle 7.
  - `SRAM_DQ` never driven by the DUT.
- **Offset mapping**: write 0xCAFEBABE to 0x40C.
  - `SRAM_ADDR` = 6 in LO and 7 in HI; SRAM[6] = 0xBABE and SRAM[7] = 0xCAFE.
  - Address bits [1:0] = 3 give the same result.
- **Wrap**: `address`=0x0 maps to offset 0x3FC00, so `SRAM_ADDR` = 0x1FE00 in LO and 0x1FE01 in HI. Data round-trips.
- **Simultaneous and changing inputs**: `wr_en`=`rd_en`=1 performs a write. Changing `address` and `write_data` mid-transaction does not alter the accessed location or data.
- **Reset mid-operation**: assert `rst` in HI of a write.
  - Next cycle: `SRAM_WE_N` = 1, DQ = Z, state IDLE.
  - No `done` pulse.
  - A following read of 0x400 completes normally in 7 cycles.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared types and defaults for the cache-side SRAM access engine.
package sram_pkg;
  typedef enum logic [1:0] {IDLE, LO, HI, FIN} state_t;

  localparam int unsigned SRAM_AW         = 18;
  localparam int unsigned SRAM_DW         = 16;
  localparam int unsigned DEF_BASE_OFFSET = 1024;
  localparam int unsigned DEF_WAIT_CYCLES = 2;
endpackage

// File: rtl/sram_access_engine_if.sv
// Cache-controller request bus: one 32-bit word read or write per transaction.
interface sram_access_engine_if;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        done;

  modport master (output wr_en, rd_en, address, write_data, input read_data, done);
  modport slave  (input wr_en, rd_en, address, write_data, output read_data, done);
endinterface

// File: rtl/sram_access_engine.sv
// Executes one word request as two 16-bit SRAM accesses (low halfword first)
// in the data-memory window starting at BASE_OFFSET.
module sram_access_engine
  import sram_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter int unsigned BASE_OFFSET = DEF_BASE_OFFSET
) (
  input  logic                 clk,
  input  logic                 rst,
  sram_access_engine_if.slave  req,
  inout  wire  [SRAM_DW-1:0]   SRAM_DQ,
  output logic [SRAM_AW-1:0]   SRAM_ADDR,
  output logic                 SRAM_WE_N
);

  localparam logic [2:0]         WAIT_LOAD = 3'(WAIT_CYCLES);
  localparam logic [SRAM_AW-1:0] BASE      = SRAM_AW'(BASE_OFFSET);

  state_t              state, state_nxt;
  logic                op_wr;
  logic [31:0]         wdata_q;
  logic [2:0]          wait_cnt;
  logic [SRAM_DW-1:0]  rd_lo;
  logic [31:0]         read_data_q;
  logic [SRAM_AW-1:0]  sram_addr;
  logic                phase_last;
  logic                drive;
  logic [SRAM_DW-1:0]  dq_out;

  assign phase_last = (wait_cnt == '0);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req.wr_en || req.rd_en) state_nxt = LO;
      LO:      if (phase_last) state_nxt = HI;
      HI:      if (phase_last) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      op_wr       <= 1'b0;
      wdata_q     <= '0;
      wait_cnt    <= '0;
      rd_lo       <= '0;
      read_data_q <= '0;
      sram_addr   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (req.wr_en || req.rd_en) begin
          op_wr     <= req.wr_en;
          wdata_q   <= req.write_data;
          // Halfword index of the word: offset[17:2] with the MSB forced to 0.
          sram_addr <= {1'b0, 16'((req.address[SRAM_AW-1:0] - BASE) >> 2), 1'b0};
          wait_cnt  <= WAIT_LOAD;
        end
        LO: if (phase_last) begin
          if (!op_wr) rd_lo <= SRAM_DQ;
          sram_addr[0] <= 1'b1;
          wait_cnt     <= WAIT_LOAD;
        end else begin
          wait_cnt <= wait_cnt - 3'd1;
        end
        HI: if (phase_last) begin
          // Whole word lands at once so read_data is never half-updated.
          if (!op_wr) read_data_q <= {SRAM_DQ, rd_lo};
        end else begin
          wait_cnt <= wait_cnt - 3'd1;
        end
        default: ;
      endcase
    end
  end

  assign drive     = op_wr && (state == LO || state == HI);
  assign dq_out    = (state == HI) ? wdata_q[31:16] : wdata_q[15:0];
  assign SRAM_DQ   = drive ? dq_out : 'z;
  assign SRAM_WE_N = !(drive && !phase_last);
  assign SRAM_ADDR = sram_addr;

  assign req.done      = (state == FIN);
  assign req.read_data = read_data_q;

endmodule
